// File: rtl/prs_counter_bank.sv
// PRS pulse-counting core: per-channel synchronised edge counters with an
// atomic snapshot-and-clear handshake and a level-based config port.

module prs_ch_lane #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ch,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_mode,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic [1:0]             mode_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q;
    logic                   rise, fall, evt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            mode_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_ch};
            dly_q  <= sync_q[SYNC_STAGES-1];
            if (i_cfg_we)
                mode_q <= i_cfg_mode;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & dly_q;
    assign evt  = (mode_q[0] & rise) | (mode_q[1] & fall);

    // On a snapshot the counter restarts from this cycle's event so nothing is lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (i_clr) begin
            cnt_q <= {{(CNT_W-1){1'b0}}, evt};
            ovf_q <= 1'b0;
        end else if (evt) begin
            if (cnt_q == CNT_MAX) begin
                ovf_q <= 1'b1;
                if (SATURATE == 0)
                    cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_cnt = cnt_q;
    assign o_ovf = ovf_q;
endmodule

module prs_counter_bank #(
    parameter int NUM_CH      = 16,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH-1:0]       i_ch,
    input  logic [2*NUM_CH-1:0]     i_cfg_data,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ack,
    input  logic                    i_snap_req,
    output logic                    o_snap_valid,
    input  logic                    i_snap_ack,
    output logic [NUM_CH*CNT_W-1:0] o_snap_data,
    output logic [NUM_CH-1:0]       o_snap_ovf,
    output logic                    o_busy
);
    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    state_t                         state_q, state_d;
    logic                           snap_take, cfg_apply;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt;
    logic [NUM_CH-1:0]              ovf;
    logic [NUM_CH-1:0][CNT_W-1:0]   snap_data_q;
    logic [NUM_CH-1:0]              snap_ovf_q;
    logic                           cfg_ack_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        prs_ch_lane #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES),
            .SATURATE   (SATURATE)
        ) u_lane (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_ch      (i_ch[g]),
            .i_cfg_we  (cfg_apply),
            .i_cfg_mode(i_cfg_data[2*g +: 2]),
            .i_clr     (snap_take),
            .o_cnt     (cnt[g]),
            .o_ovf     (ovf[g])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Snapshot wins over config; config only lands in IDLE with no request pending.
    always_comb begin
        state_d   = state_q;
        snap_take = 1'b0;
        cfg_apply = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_snap_req) begin
                    snap_take = 1'b1;
                    state_d   = S_HOLD;
                end else if (i_cfg_valid) begin
                    cfg_apply = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_snap_ack)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap_data_q <= '0;
            snap_ovf_q  <= '0;
            cfg_ack_q   <= 1'b0;
        end else begin
            cfg_ack_q <= cfg_apply;
            if (snap_take) begin
                snap_data_q <= cnt;
                snap_ovf_q  <= ovf;
            end
        end
    end

    assign o_snap_data  = snap_data_q;
    assign o_snap_ovf   = snap_ovf_q;
    assign o_cfg_ack    = cfg_ack_q;
    assign o_snap_valid = (state_q == S_HOLD);
    assign o_busy       = (state_q == S_HOLD);
endmodule

// File: tb/tb_prs_counter_bank.sv
// Bench for prs_counter_bank: a saturating and a wrapping instance share the
// same stimulus and are checked against an event-count reference model.

module tb_prs_counter_bank;
    localparam int NUM_CH = 16;
    localparam int CNT_W  = 8;
    localparam int SYNC   = 2;
    localparam int DW     = NUM_CH * CNT_W;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic                i_clk = 1'b0;
    logic                i_rst_n = 1'b0;
    logic [NUM_CH-1:0]   ch_drv = '0;
    logic [2*NUM_CH-1:0] cfg_data = '0;
    logic                cfg_valid = 1'b0, snap_req = 1'b0, snap_ack = 1'b0;
    logic                ack_s, val_s, busy_s, ack_w, val_w, busy_w;
    logic [DW-1:0]       data_s, data_w;
    logic [NUM_CH-1:0]   ovf_s, ovf_w;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    prs_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .SATURATE(1)) u_sat (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ch(ch_drv), .i_cfg_data(cfg_data),
        .i_cfg_valid(cfg_valid), .o_cfg_ack(ack_s), .i_snap_req(snap_req),
        .o_snap_valid(val_s), .i_snap_ack(snap_ack), .o_snap_data(data_s),
        .o_snap_ovf(ovf_s), .o_busy(busy_s));

    prs_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .SATURATE(0)) u_wrap (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ch(ch_drv), .i_cfg_data(cfg_data),
        .i_cfg_valid(cfg_valid), .o_cfg_ack(ack_w), .i_snap_req(snap_req),
        .o_snap_valid(val_w), .i_snap_ack(snap_ack), .o_snap_data(data_w),
        .o_snap_ovf(ovf_w), .o_busy(busy_w));

    // Reference: unbounded event totals per channel; snapshot reduces them to
    // saturated / modulo values. A pin level sampled at edge k counts at edge k+SYNC.
    logic [NUM_CH-1:0] smp [0:SYNC];
    logic [1:0]        mode_m [NUM_CH];
    int                n_m [NUM_CH];
    int                esat [NUM_CH];
    int                ewrap [NUM_CH];
    logic [NUM_CH-1:0] eovf;
    logic              hold_m, ack_m;

    function automatic logic ev_of(int i);
        logic now_l, old_l;
        now_l = smp[SYNC-1][i];
        old_l = smp[SYNC][i];
        case (mode_m[i])
            2'b01:   return now_l && !old_l;
            2'b10:   return !now_l && old_l;
            2'b11:   return now_l != old_l;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j <= SYNC; j++) smp[j] <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_m[i] <= 2'b00; n_m[i] <= 0; esat[i] <= 0; ewrap[i] <= 0;
            end
            eovf <= '0; hold_m <= 1'b0; ack_m <= 1'b0;
        end else begin
            for (int j = 1; j <= SYNC; j++) smp[j] <= smp[j-1];
            smp[0] <= ch_drv;
            ack_m  <= !hold_m && !snap_req && cfg_valid;
            if (!hold_m && snap_req) begin
                hold_m <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    esat[i]  <= (n_m[i] > MAXV) ? MAXV : n_m[i];
                    ewrap[i] <= n_m[i] % (MAXV + 1);
                    eovf[i]  <= n_m[i] > MAXV;
                    n_m[i]   <= ev_of(i) ? 1 : 0;
                end
            end else begin
                for (int i = 0; i < NUM_CH; i++) n_m[i] <= n_m[i] + (ev_of(i) ? 1 : 0);
                if (hold_m && snap_ack) hold_m <= 1'b0;
            end
            if (!hold_m && !snap_req && cfg_valid)
                for (int i = 0; i < NUM_CH; i++) mode_m[i] <= cfg_data[2*i +: 2];
        end
    end

    task automatic chk(string nm, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic check_model(string nm);
        logic [DW-1:0] xs, xw;
        for (int i = 0; i < NUM_CH; i++) begin
            xs[i*CNT_W +: CNT_W] = CNT_W'(esat[i]);
            xw[i*CNT_W +: CNT_W] = CNT_W'(ewrap[i]);
        end
        chk({nm, "_vld"},  DW'({val_s, busy_s, val_w, busy_w}), DW'({4{hold_m}}));
        chk({nm, "_cack"}, DW'({ack_s, ack_w}), DW'({2{ack_m}}));
        chk({nm, "_dsat"}, data_s, xs);
        chk({nm, "_dwrap"}, data_w, xw);
        chk({nm, "_ovf"}, DW'({ovf_s, ovf_w}), DW'({eovf, eovf}));
    endtask

    task automatic cfg(string nm, logic [2*NUM_CH-1:0] w);
        int t = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        do begin @(negedge i_clk); t++; end while (!ack_s && t < 20);
        cfg_valid = 1'b0;
        chk({nm, "_ack_lat"}, DW'(t), DW'(1));
        @(negedge i_clk);
        chk({nm, "_ack_once"}, DW'({ack_s, ack_w}), '0);
    endtask

    task automatic snap(string nm, output logic [DW-1:0] ds, output logic [DW-1:0] dw,
                        output logic [NUM_CH-1:0] os, output logic [NUM_CH-1:0] ow);
        int t = 0;
        snap_req = 1'b1;
        do begin @(negedge i_clk); t++; end while (!val_s && t < 20);
        snap_req = 1'b0;
        chk({nm, "_lat"}, DW'(t), DW'(1));
        check_model(nm);
        ds = data_s; dw = data_w; os = ovf_s; ow = ovf_w;
        snap_ack = 1'b1;
        @(negedge i_clk);
        snap_ack = 1'b0;
        chk({nm, "_rel"}, DW'({val_s, busy_s}), '0);
    endtask

    task automatic pulse(int c, int n);
        repeat (n) begin
            ch_drv[c] = 1'b1; repeat (2) @(negedge i_clk);
            ch_drv[c] = 1'b0; repeat (2) @(negedge i_clk);
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        int         ch;
        int         np;
        int         es;
        int         ew;
        logic       eo;
    } vec_t;

    vec_t                tbl [9];
    logic [DW-1:0]       ds, dw;
    logic [NUM_CH-1:0]   os, ow;
    logic [2*NUM_CH-1:0] w;
    int                  age [NUM_CH];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b01, 0,   5,   5,   5, 1'b0};
        tbl[1] = '{2'b11, 1,   4,   8,   8, 1'b0};
        tbl[2] = '{2'b10, 2,   4,   4,   4, 1'b0};
        tbl[3] = '{2'b00, 3,   4,   0,   0, 1'b0};
        tbl[4] = '{2'b01, 0, 300, 255,  44, 1'b1};
        tbl[5] = '{2'b11, 5, 150, 255,  44, 1'b1};
        tbl[6] = '{2'b01, 7, 255, 255, 255, 1'b0};
        tbl[7] = '{2'b01, 7, 256, 255,   0, 1'b1};
        tbl[8] = '{2'b10, 9,   1,   1,   1, 1'b0};
        for (int i = 0; i < NUM_CH; i++) age[i] = 2;

        repeat (3) @(negedge i_clk);
        chk("rst_data", data_s | data_w, '0);
        chk("rst_ctl", DW'({val_s, busy_s, ack_s, val_w, busy_w, ack_w, ovf_s, ovf_w}), '0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // all channels rising-edge; 5 pulses on ch0, 3 on ch15
        cfg("basic_cfg", {NUM_CH{2'b01}});
        pulse(0, 5);
        pulse(15, 3);
        repeat (4) @(negedge i_clk);
        snap("basic", ds, dw, os, ow);
        chk("basic_data", ds, (DW'(3) << (15*CNT_W)) | DW'(5));
        chk("basic_ovf", DW'({os, ow}), '0);

        for (int v = 0; v < 9; v++) begin
            w = {NUM_CH{2'b01}};
            w[2*tbl[v].ch +: 2] = tbl[v].mode;
            cfg($sformatf("t%0d_cfg", v), w);
            snap($sformatf("t%0d_clr", v), ds, dw, os, ow);
            pulse(tbl[v].ch, tbl[v].np);
            repeat (4) @(negedge i_clk);
            snap($sformatf("t%0d", v), ds, dw, os, ow);
            chk($sformatf("t%0d_sat", v), DW'(ds[tbl[v].ch*CNT_W +: CNT_W]), DW'(tbl[v].es));
            chk($sformatf("t%0d_wrap", v), DW'(dw[tbl[v].ch*CNT_W +: CNT_W]), DW'(tbl[v].ew));
            chk($sformatf("t%0d_ovf", v), DW'({os[tbl[v].ch], ow[tbl[v].ch]}), DW'({2{tbl[v].eo}}));
            if (tbl[v].eo) begin
                snap($sformatf("t%0d_after", v), ds, dw, os, ow);
                chk($sformatf("t%0d_after", v), DW'({ds, dw, os, ow}), '0);
            end
        end

        // edge counted on the very snapshot edge lands in the next snapshot
        cfg("se_cfg", {NUM_CH{2'b01}});
        snap("se_clr", ds, dw, os, ow);
        ch_drv[4] = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        snap_req = 1'b1;
        @(negedge i_clk);
        snap_req = 1'b0;
        chk("se_valid", DW'(val_s), DW'(1));
        chk("se_excl", DW'(data_s[4*CNT_W +: CNT_W]), '0);
        check_model("se_snap");
        snap_ack = 1'b1;
        @(negedge i_clk);
        snap_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        snap("se_next", ds, dw, os, ow);
        chk("se_next_ch4", DW'(ds[4*CNT_W +: CNT_W]), DW'(1));
        ch_drv[4] = 1'b0;
        repeat (4) @(negedge i_clk);

        // counting continues while the snapshot is held
        snap_req = 1'b1;
        @(negedge i_clk);
        snap_req = 1'b0;
        pulse(6, 2);
        repeat (3) @(negedge i_clk);
        chk("hold_still_valid", DW'({val_s, busy_s}), DW'(2'b11));
        check_model("hold_frozen");
        snap_ack = 1'b1;
        @(negedge i_clk);
        snap_ack = 1'b0;
        snap("hold_next", ds, dw, os, ow);
        chk("hold_next_ch6", DW'(ds[6*CNT_W +: CNT_W]), DW'(2));

        // config and snapshot together: snapshot first, config after release
        cfg_data  = {NUM_CH{2'b11}};
        cfg_valid = 1'b1;
        snap_req  = 1'b1;
        @(negedge i_clk);
        snap_req = 1'b0;
        chk("cs_snap_first", DW'({val_s, ack_s}), DW'(2'b10));
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk($sformatf("cs_stall%0d", k), DW'(ack_s), '0);
        end
        snap_ack = 1'b1;
        @(negedge i_clk);
        snap_ack = 1'b0;
        chk("cs_release", DW'({val_s, ack_s}), '0);
        @(negedge i_clk);
        chk("cs_ack", DW'({ack_s, ack_w}), DW'(2'b11));
        cfg_valid = 1'b0;
        @(negedge i_clk);
        chk("cs_ack_drop", DW'({ack_s, ack_w}), '0);
        pulse(9, 1);
        repeat (4) @(negedge i_clk);
        snap("cs_mode", ds, dw, os, ow);
        chk("cs_mode_ch9", DW'(ds[9*CNT_W +: CNT_W]), DW'(2));

        // randomized modes and pin activity against the model
        for (int r = 0; r < 10; r++) begin
            cfg($sformatf("rnd%0d_cfg", r), (2*NUM_CH)'($urandom));
            repeat (20 + $urandom_range(60)) begin
                @(negedge i_clk);
                for (int i = 0; i < NUM_CH; i++) begin
                    age[i]++;
                    if (age[i] >= 2 && $urandom_range(3) == 0) begin
                        ch_drv[i] = ~ch_drv[i];
                        age[i] = 0;
                    end
                end
            end
            snap($sformatf("rnd%0d", r), ds, dw, os, ow);
        end
        ch_drv = '0;
        repeat (4) @(negedge i_clk);

        // reset while holding a nonzero snapshot
        cfg("rh_cfg", {NUM_CH{2'b01}});
        snap("rh_clr", ds, dw, os, ow);
        pulse(0, 3);
        repeat (4) @(negedge i_clk);
        snap_req = 1'b1;
        @(negedge i_clk);
        snap_req = 1'b0;
        pulse(0, 2);
        chk("rh_pre_data", DW'(data_s[CNT_W-1:0]), DW'(3));
        #2 i_rst_n = 1'b0;
        #1;
        chk("rh_data", data_s | data_w, '0);
        chk("rh_ctl", DW'({val_s, busy_s, ack_s, val_w, busy_w, ack_w, ovf_s, ovf_w}), '0);
        check_model("rh_model");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        pulse(0, 3);
        pulse(1, 3);
        repeat (4) @(negedge i_clk);
        snap("rh_after", ds, dw, os, ow);
        chk("rh_after_zero", DW'({ds, dw, os, ow}), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
